// File: rtl/xaddrgen_pkg.sv
// xaddrgen_pkg: shared definitions for the xaddrgen address generator.
//   - default address / period widths
//   - FSM state encoding
//   - bit layout used when the configuration is packed into one register word
package xaddrgen_pkg;

    localparam int unsigned AddrWDef   = 10;
    localparam int unsigned PeriodWDef = 10;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StActive = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Packed configuration word layout (LSB first) at default widths:
    // iterations | period | duty | delay | start | incr | shift
    localparam int unsigned CfgIterLsb   = 0;
    localparam int unsigned CfgPeriodLsb = CfgIterLsb + PeriodWDef;
    localparam int unsigned CfgDutyLsb   = CfgPeriodLsb + PeriodWDef;
    localparam int unsigned CfgDelayLsb  = CfgDutyLsb + PeriodWDef;
    localparam int unsigned CfgStartLsb  = CfgDelayLsb + PeriodWDef;
    localparam int unsigned CfgIncrLsb   = CfgStartLsb + AddrWDef;
    localparam int unsigned CfgShiftLsb  = CfgIncrLsb + AddrWDef;
    localparam int unsigned CfgWidth     = CfgShiftLsb + AddrWDef;

endpackage

// File: rtl/xaddrgen.sv
// xaddrgen: programmable 2-D address generator for a Versat memory port.
// After an accepted run it waits delay_i cycles, then emits iterations_i periods of
// period_i cycles each; the first duty_i cycles of a period assert mem_en_o and step
// the address by incr_i, and every period end adds shift_i. done_o is held high
// once the sequence finishes, until the next accepted run.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   run_i         start pulse, accepted only in IDLE or DONE
//   pause_i       freezes the sequence while high (DELAY / ACTIVE only)
//   iterations_i  number of periods
//   period_i      cycles per period
//   duty_i        enabled cycles at the start of each period
//   delay_i       idle cycles between run and the first period
//   start_i       first address
//   incr_i        signed step per enabled cycle
//   shift_i       signed extra step at each period end
//   addr_o        registered memory address
//   mem_en_o      registered memory enable
//   done_o        sequence finished
module xaddrgen
    import xaddrgen_pkg::*;
#(
    parameter int unsigned ADDR_W   = AddrWDef,
    parameter int unsigned PERIOD_W = PeriodWDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic                pause_i,
    input  logic [PERIOD_W-1:0] iterations_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PERIOD_W-1:0] duty_i,
    input  logic [PERIOD_W-1:0] delay_i,
    input  logic [ADDR_W-1:0]   start_i,
    input  logic [ADDR_W-1:0]   incr_i,
    input  logic [ADDR_W-1:0]   shift_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                mem_en_o,
    output logic                done_o
);

    localparam logic [PERIOD_W-1:0] POne = PERIOD_W'(1);

    state_e state_q, state_d;

    // Configuration latched on an accepted run
    logic [PERIOD_W-1:0] iter_cfg_q, iter_cfg_d;
    logic [PERIOD_W-1:0] period_cfg_q, period_cfg_d;
    logic [PERIOD_W-1:0] duty_cfg_q, duty_cfg_d;
    logic [PERIOD_W-1:0] delay_cfg_q, delay_cfg_d;
    logic [ADDR_W-1:0]   incr_cfg_q, incr_cfg_d;
    logic [ADDR_W-1:0]   shift_cfg_q, shift_cfg_d;

    // ptr_q is the address to present on the next unpaused ACTIVE cycle; addr_q is
    // what is on the port now.
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_en_q, mem_en_d;
    logic                done_q, done_d;
    logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [PERIOD_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [PERIOD_W-1:0] dly_cnt_q, dly_cnt_d;

    logic accept;
    logic cfg_empty;
    logic in_empty;
    logic dly_last;
    logic per_last;
    logic iter_last;
    logic en;

    assign accept    = run_i && ((state_q == StIdle) || (state_q == StDone));
    assign in_empty  = (iterations_i == '0) || (period_i == '0);
    assign cfg_empty = (iter_cfg_q == '0) || (period_cfg_q == '0);
    assign dly_last  = (dly_cnt_q == delay_cfg_q - POne);
    assign per_last  = (per_cnt_q == period_cfg_q - POne);
    assign iter_last = (iter_cnt_q == iter_cfg_q - POne);
    assign en        = (per_cnt_q < duty_cfg_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (delay_i != '0) begin
                        state_d = StDelay;
                    end else if (in_empty) begin
                        state_d = StDone;
                    end else begin
                        state_d = StActive;
                    end
                end
            end
            StDelay: begin
                if (!pause_i && dly_last) begin
                    state_d = cfg_empty ? StDone : StActive;
                end
            end
            StActive: begin
                if (!pause_i && per_last && iter_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next-state logic
    always_comb begin
        iter_cfg_d   = iter_cfg_q;
        period_cfg_d = period_cfg_q;
        duty_cfg_d   = duty_cfg_q;
        delay_cfg_d  = delay_cfg_q;
        incr_cfg_d   = incr_cfg_q;
        shift_cfg_d  = shift_cfg_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        mem_en_d     = 1'b0;
        done_d       = 1'b0;
        per_cnt_d    = per_cnt_q;
        iter_cnt_d   = iter_cnt_q;
        dly_cnt_d    = dly_cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                done_d = (state_q == StDone);
                if (accept) begin
                    iter_cfg_d   = iterations_i;
                    period_cfg_d = period_i;
                    duty_cfg_d   = duty_i;
                    delay_cfg_d  = delay_i;
                    incr_cfg_d   = incr_i;
                    shift_cfg_d  = shift_i;
                    ptr_d        = start_i;
                    addr_d       = start_i;
                    per_cnt_d    = '0;
                    iter_cnt_d   = '0;
                    dly_cnt_d    = '0;
                    done_d       = 1'b0;
                end
            end
            StDelay: begin
                if (!pause_i) begin
                    dly_cnt_d = dly_cnt_q + POne;
                end
            end
            StActive: begin
                // Paused or not, the port shows the pending address; only the
                // unpaused case consumes it.
                addr_d = ptr_q;
                if (!pause_i) begin
                    mem_en_d = en;
                    ptr_d    = ptr_q + (en ? incr_cfg_q : '0) + (per_last ? shift_cfg_q : '0);
                    if (per_last) begin
                        per_cnt_d  = '0;
                        iter_cnt_d = iter_cnt_q + POne;
                    end else begin
                        per_cnt_d = per_cnt_q + POne;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cfg_q   <= '0;
            period_cfg_q <= '0;
            duty_cfg_q   <= '0;
            delay_cfg_q  <= '0;
            incr_cfg_q   <= '0;
            shift_cfg_q  <= '0;
            ptr_q        <= '0;
            addr_q       <= '0;
            mem_en_q     <= 1'b0;
            done_q       <= 1'b0;
            per_cnt_q    <= '0;
            iter_cnt_q   <= '0;
            dly_cnt_q    <= '0;
        end else begin
            iter_cfg_q   <= iter_cfg_d;
            period_cfg_q <= period_cfg_d;
            duty_cfg_q   <= duty_cfg_d;
            delay_cfg_q  <= delay_cfg_d;
            incr_cfg_q   <= incr_cfg_d;
            shift_cfg_q  <= shift_cfg_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            mem_en_q     <= mem_en_d;
            done_q       <= done_d;
            per_cnt_q    <= per_cnt_d;
            iter_cnt_q   <= iter_cnt_d;
            dly_cnt_q    <= dly_cnt_d;
        end
    end

    assign addr_o   = addr_q;
    assign mem_en_o = mem_en_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_xaddrgen.sv
// tb_xaddrgen: table-driven bench for xaddrgen with a per-cycle scoreboard, plus
// hand-written reset sequences.
module tb_xaddrgen;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_i;
    logic       pause_i;
    logic [9:0] iterations_i;
    logic [9:0] period_i;
    logic [9:0] duty_i;
    logic [9:0] delay_i;
    logic [9:0] start_i;
    logic [9:0] incr_i;
    logic [9:0] shift_i;
    logic [9:0] addr_o;
    logic       mem_en_o;
    logic       done_o;

    xaddrgen dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .pause_i      (pause_i),
        .iterations_i (iterations_i),
        .period_i     (period_i),
        .duty_i       (duty_i),
        .delay_i      (delay_i),
        .start_i      (start_i),
        .incr_i       (incr_i),
        .shift_i      (shift_i),
        .addr_o       (addr_o),
        .mem_en_o     (mem_en_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned iter;
        int unsigned period;
        int unsigned duty;
        int unsigned delay;
        logic [9:0]  start;
        logic [9:0]  incr;
        logic [9:0]  shift;
        int          p0;        // first paused cycle, -1 for none
        int          p1;        // last paused cycle
        int          rerun;     // cycle with an extra (ignored) run, -1 for none
        int          exp_en;    // number of enabled cycles
        int          exp_first; // first enabled address
        int          exp_last;  // last enabled address
        int          exp_fcyc;  // cycle of first enable
        int          exp_done;  // cycle where done first reads 1
    } vec_t;

    typedef struct {
        logic [9:0] addr;
        logic       en;
    } step_t;

    typedef struct {
        logic [9:0] addr;
        logic       en;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        step_t      s[$];
        logic [9:0] a;
        logic [9:0] last_a;
        exp_t       e;
        exp_t       got;
        int         idx;
        int         ncyc;
        int         npause;
        int         o_en, o_first, o_last, o_fcyc, o_done;

        // Reference trace: delay steps, then nested period/iteration loops
        a = v.start;
        for (int d = 0; d < int'(v.delay); d++) s.push_back('{v.start, 1'b0});
        if (v.iter != 0 && v.period != 0) begin
            for (int it = 0; it < int'(v.iter); it++) begin
                for (int p = 0; p < int'(v.period); p++) begin
                    s.push_back('{a, (p < int'(v.duty))});
                    if (p < int'(v.duty)) a = a + v.incr;
                    if (p == int'(v.period) - 1) a = a + v.shift;
                end
            end
        end
        last_a = (s.size() > 0) ? s[s.size()-1].addr : v.start;
        npause = (v.p0 >= 0) ? (v.p1 - v.p0 + 1) : 0;
        ncyc   = s.size() + npause + 3;

        @(negedge clk);
        iterations_i = 10'(v.iter);
        period_i     = 10'(v.period);
        duty_i       = 10'(v.duty);
        delay_i      = 10'(v.delay);
        start_i      = v.start;
        incr_i       = v.incr;
        shift_i      = v.shift;
        pause_i      = 1'b0;
        run_i        = 1'b1;
        sb.push_back('{v.start, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        got = '{addr_o, mem_en_o, done_o};
        e = sb.pop_front();
        chk($sformatf("v%0d accept", id), int'({got.addr, got.en, got.done}),
            int'({e.addr, e.en, e.done}));

        o_en = 0; o_first = -1; o_last = -1; o_fcyc = -1; o_done = -1;
        idx = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            pause_i = (v.p0 >= 0) && (n >= v.p0) && (n <= v.p1);
            run_i   = (n == v.rerun);
            // Configuration changes after acceptance must be ignored
            iterations_i = 10'($urandom_range(0, 15));
            period_i     = 10'($urandom_range(0, 15));
            duty_i       = 10'($urandom_range(0, 15));
            delay_i      = 10'($urandom_range(0, 15));
            start_i      = 10'($urandom);
            incr_i       = 10'($urandom);
            shift_i      = 10'($urandom);
            if (idx < s.size()) begin
                if (pause_i) begin
                    e = '{s[idx].addr, 1'b0, 1'b0};
                end else begin
                    e = '{s[idx].addr, s[idx].en, 1'b0};
                    idx++;
                end
            end else begin
                e = '{last_a, 1'b0, 1'b1};
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = '{addr_o, mem_en_o, done_o};
            e = sb.pop_front();
            chk($sformatf("v%0d cyc%0d {addr,en,done}", id, n),
                int'({got.addr, got.en, got.done}), int'({e.addr, e.en, e.done}));
            if (mem_en_o) begin
                o_en++;
                if (o_first < 0) begin
                    o_first = int'(addr_o);
                    o_fcyc  = n;
                end
                o_last = int'(addr_o);
            end
            if (done_o && o_done < 0) o_done = n;
        end
        run_i   = 1'b0;
        pause_i = 1'b0;
        chk($sformatf("v%0d en_count", id), o_en, v.exp_en);
        chk($sformatf("v%0d first_addr", id), o_first, v.exp_first);
        chk($sformatf("v%0d last_addr", id), o_last, v.exp_last);
        chk($sformatf("v%0d first_en_cycle", id), o_fcyc, v.exp_fcyc);
        chk($sformatf("v%0d done_cycle", id), o_done, v.exp_done);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " addr"}, int'(addr_o), 0);
        chk({nm, " mem_en"}, int'(mem_en_o), 0);
        chk({nm, " done"}, int'(done_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        //         iter per duty dly start    incr     shift    p0 p1 rerun en first last fcyc done
        vecs[0]  = '{2, 4, 4, 0, 10'd0,    10'd1,   10'd0,   -1, -1, -1, 8, 0,    7,   1,  9};
        vecs[1]  = '{3, 4, 3, 0, 10'd0,    10'd1,   10'd5,   -1, -1, -1, 9, 0,    18,  1,  13};
        vecs[2]  = '{2, 4, 4, 5, 10'd0,    10'd1,   10'd0,   -1, -1, 7,  8, 0,    7,   6,  14};
        vecs[3]  = '{2, 4, 4, 0, 10'd0,    10'd1,   10'd0,   3,  5,  -1, 8, 0,    7,   1,  12};
        vecs[4]  = '{0, 4, 4, 0, 10'd0,    10'd1,   10'd0,   -1, -1, -1, 0, -1,   -1,  -1, 1};
        vecs[5]  = '{1, 3, 3, 0, 10'd1023, 10'd1,   10'd0,   -1, -1, -1, 3, 1023, 1,   1,  4};
        vecs[6]  = '{1, 4, 4, 0, 10'd5,    10'h3FF, 10'd0,   -1, -1, -1, 4, 5,    2,   1,  5};
        vecs[7]  = '{2, 3, 0, 0, 10'd0,    10'd1,   10'd0,   -1, -1, -1, 0, -1,   -1,  -1, 7};
        vecs[8]  = '{3, 0, 2, 2, 10'd0,    10'd1,   10'd0,   -1, -1, -1, 0, -1,   -1,  -1, 3};
        vecs[9]  = '{1, 3, 7, 0, 10'd10,   10'd2,   10'd0,   -1, -1, -1, 3, 10,   14,  1,  4};
        vecs[10] = '{1, 2, 2, 3, 10'd0,    10'd1,   10'd0,   2,  3,  -1, 2, 0,    1,   6,  8};
        vecs[11] = '{2, 2, 2, 0, 10'd100,  10'd1,   10'h3FE, -1, -1, -1, 4, 100,  101, 1,  5};

        rst = 1'b1; run_i = 1'b0; pause_i = 1'b0;
        iterations_i = '0; period_i = '0; duty_i = '0; delay_i = '0;
        start_i = '0; incr_i = '0; shift_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the 1-D linear sequence
        @(negedge clk);
        iterations_i = 10'd2; period_i = 10'd4; duty_i = 10'd4; delay_i = 10'd0;
        start_i = 10'd0; incr_i = 10'd1; shift_i = 10'd0;
        run_i = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            run_i = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("pre-reset cyc%0d addr", n), int'(addr_o), n - 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("mid-run reset");
        // run together with rst: reset wins
        @(negedge clk);
        run_i = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst+run");
        @(negedge clk);
        rst = 1'b0;
        run_i = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("idle after rst+run");

        // A fresh run reproduces the 1-D linear sequence
        run_vec(12, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
